// File: rtl/data_sram_ctrl_if.sv
// MEM-stage request/response bus seen by the data-side SRAM controller.
// The master is the MEM stage; the slave is the controller.
interface data_sram_ctrl_if;
  logic        ce_i;
  logic        we_n_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_req;

  modport master (
    output ce_i, we_n_i, sel_i, addr_i, wdata_i,
    input  rdata_o, stall_req
  );

  modport slave (
    input  ce_i, we_n_i, sel_i, addr_i, wdata_i,
    output rdata_o, stall_req
  );
endinterface

// File: rtl/data_sram_ctrl.sv
// Data-side controller for an external asynchronous 32-bit SRAM with a fixed
// number of wait states; freezes the pipeline while an access is in flight.
module data_sram_ctrl #(
  parameter int SRAM_AW     = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_sram_ctrl_if.slave    bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_i,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] COUNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  count;
  logic        op_store;
  logic        op_byte;
  logic [1:0]  op_lane;
  logic        accept;
  logic        finish;
  logic [7:0]  load_byte;
  logic [31:0] load_result;

  // Upper byte-address bits fall outside the SRAM and are discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr_i[31:SRAM_AW+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    finish        = 1'b0;
    bus.stall_req = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ce_i) begin
          accept        = 1'b1;
          bus.stall_req = 1'b1;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        bus.stall_req = 1'b1;
        if (count == 4'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Loads pick the latched lane from the live SRAM bus at the final ACCESS edge.
  always_comb begin
    load_byte   = sram_dq_i[{op_lane, 3'b000} +: 8];
    load_result = sram_dq_i;
    if (op_store) begin
      load_result = 32'h0;
    end else if (op_byte) begin
      load_result = {{24{load_byte[7]}}, load_byte};
    end
  end

  // SRAM pins are registered at accept so they stay stable across ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= 4'd0;
      op_store    <= 1'b0;
      op_byte     <= 1'b0;
      op_lane     <= 2'd0;
      bus.rdata_o <= 32'h0;
      sram_addr   <= '0;
      sram_dq_o   <= 32'h0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= 4'b1111;
    end else if (accept) begin
      count      <= COUNT_INIT;
      op_store   <= ~bus.we_n_i;
      op_byte    <= (bus.sel_i != 4'b0000);
      op_lane    <= bus.addr_i[1:0];
      sram_addr  <= bus.addr_i[SRAM_AW+1:2];
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= ~bus.we_n_i;
      sram_we_n  <= bus.we_n_i;
      sram_dq_oe <= ~bus.we_n_i;
      if (bus.sel_i != 4'b0000) begin
        sram_dq_o <= {4{bus.wdata_i[7:0]}};
        sram_be_n <= ~(4'b0001 << bus.addr_i[1:0]);
      end else begin
        sram_dq_o <= bus.wdata_i;
        sram_be_n <= 4'b0000;
      end
    end else if (finish) begin
      bus.rdata_o <= load_result;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_be_n   <= 4'b1111;
    end else if (state == ACCESS) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Self-checking bench for data_sram_ctrl: a behavioural SRAM, a vector table of
// single accesses with a result scoreboard, and hand sequences for corner cases.
module tb_data_sram_ctrl;

  localparam int W  = 2;
  localparam int AW = 20;

  typedef struct {
    logic          we_n;
    logic [3:0]    sel;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_be;
    logic [31:0]   exp_dq;
    logic [31:0]   exp_rdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_o;
  logic          sram_dq_oe;
  logic [31:0]   sram_dq_i;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  vec_t        vecs [13];
  int          vec_count   = 0;
  int          miscompares = 0;

  data_sram_ctrl_if bus ();

  data_sram_ctrl #(
    .SRAM_AW    (AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i (sram_dq_i),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_be_n (sram_be_n)
  );

  always #5 clk = ~clk;

  // Read data only appears while the chip is selected and outputs enabled.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0BAD_F00D;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
      end
    end
  end

  task automatic check_output(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we_n, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [AW-1:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_dq, input logic [31:0] exp_rdata);
    vec_t v;
    v.we_n = we_n; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_dq = exp_dq; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Called at a negedge with the controller idle; returns in the DONE cycle.
  // After the accept edge ce_i drops and every request input is scrambled.
  task automatic apply_stimulus(input vec_t v, input int idx);
    int          acc   = 0;
    int          stl   = 0;
    int          we_lo = 0;
    bit          done  = 1'b0;
    logic [31:0] exp;
    bus.ce_i    = 1'b1;
    bus.we_n_i  = v.we_n;
    bus.sel_i   = v.sel;
    bus.addr_i  = v.addr;
    bus.wdata_i = v.wdata;
    exp_q.push_back(v.exp_rdata);
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus.stall_req) stl++;
      if (!sram_ce_n) begin
        acc++;
        if (!sram_we_n) we_lo++;
        if (acc == 1) begin
          check_output("sram_addr", idx, 32'(sram_addr), 32'(v.exp_addr));
          check_output("sram_be_n", idx, 32'(sram_be_n), 32'(v.exp_be));
          check_output("sram_dq_o", idx, sram_dq_o, v.exp_dq);
          check_output("strobes_oe_we_dqoe", idx, 32'({sram_oe_n, sram_we_n, sram_dq_oe}),
                       32'({~v.we_n, v.we_n, ~v.we_n}));
        end
      end else if (c > 0) begin
        done = 1'b1;
        check_output("done_stall", idx, 32'(bus.stall_req), 32'd0);
        check_output("done_strobes", idx, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}),
                     32'b1110);
        exp = exp_q.pop_front();
        check_output("rdata_o", idx, bus.rdata_o, exp);
      end
      if (!done) begin
        @(posedge clk);
        if (c == 0) begin
          #1;
          bus.ce_i    = 1'b0;
          bus.we_n_i  = ~v.we_n;
          bus.sel_i   = ~v.sel;
          bus.addr_i  = ~v.addr;
          bus.wdata_i = ~v.wdata;
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      check_output("timeout", idx, 32'd0, 32'd1);
      exp = exp_q.pop_front();
    end
    check_output("access_cycles", idx, 32'(acc), 32'(W));
    check_output("stall_cycles", idx, 32'(stl), 32'(W + 1));
    check_output("we_low_cycles", idx, 32'(we_lo), v.we_n ? 32'd0 : 32'(W));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(1'b0, 4'b0000, 32'h0000_0010, 32'hDEAD_BEEF, 20'h4, 4'b0000, 32'hDEAD_BEEF, 32'h0);
    vecs[1]  = mk(1'b1, 4'b0000, 32'h0000_0010, 32'h0,         20'h4, 4'b0000, 32'h0,         32'hDEAD_BEEF);
    vecs[2]  = mk(1'b0, 4'b1110, 32'h0000_0012, 32'h0000_0080, 20'h4, 4'b1011, 32'h8080_8080, 32'h0);
    vecs[3]  = mk(1'b1, 4'b0001, 32'h0000_0012, 32'h0,         20'h4, 4'b1011, 32'h0,         32'hFFFF_FF80);
    vecs[4]  = mk(1'b0, 4'b0000, 32'h0000_0020, 32'h7F00_0000, 20'h8, 4'b0000, 32'h7F00_0000, 32'h0);
    vecs[5]  = mk(1'b1, 4'b0001, 32'h0000_0023, 32'h0,         20'h8, 4'b0111, 32'h0,         32'h0000_007F);
    vecs[6]  = mk(1'b1, 4'b0000, 32'h0000_0010, 32'h0,         20'h4, 4'b0000, 32'h0,         32'hDE80_BEEF);
    vecs[7]  = mk(1'b0, 4'b0000, 32'hFFF0_0014, 32'h1234_5678, 20'hC0005, 4'b0000, 32'h1234_5678, 32'h0);
    vecs[8]  = mk(1'b1, 4'b0000, 32'h0000_0014, 32'h0,         20'h5, 4'b0000, 32'h0,         32'h1234_5678);
    vecs[9]  = mk(1'b1, 4'b0001, 32'h0000_0014, 32'h0,         20'h5, 4'b1110, 32'h0,         32'h0000_0078);
    vecs[10] = mk(1'b0, 4'b0010, 32'h0000_0015, 32'h0000_00AB, 20'h5, 4'b1101, 32'hABAB_ABAB, 32'h0);
    vecs[11] = mk(1'b1, 4'b0001, 32'h0000_0015, 32'h0,         20'h5, 4'b1101, 32'h0,         32'hFFFF_FFAB);
    vecs[12] = mk(1'b1, 4'b0000, 32'h0000_0014, 32'h0,         20'h5, 4'b0000, 32'h0,         32'h1234_AB78);

    rst         = 1'b0;
    bus.ce_i    = 1'b0;
    bus.we_n_i  = 1'b1;
    bus.sel_i   = 4'b0000;
    bus.addr_i  = 32'h0;
    bus.wdata_i = 32'h0;

    @(negedge clk);
    #1;
    check_output("reset_strobes", 0, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
    check_output("reset_be_n", 0, 32'(sram_be_n), 32'hF);
    check_output("reset_addr", 0, 32'(sram_addr), 32'h0);
    check_output("reset_dq_o", 0, sram_dq_o, 32'h0);
    check_output("reset_rdata", 0, bus.rdata_o, 32'h0);
    check_output("reset_stall", 0, 32'(bus.stall_req), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i], i);
    end

    // Two back-to-back loads with ce_i held high: one IDLE bubble between them.
    @(negedge clk);
    bus.ce_i    = 1'b1;
    bus.we_n_i  = 1'b1;
    bus.sel_i   = 4'b0000;
    bus.addr_i  = 32'h0000_0014;
    bus.wdata_i = 32'h0;
    exp_q.push_back(32'h1234_AB78);
    exp_q.push_back(32'h1234_AB78);
    for (int c = 0; c < 2 * (2 + W); c++) begin
      int p;
      logic [31:0] exp;
      p = c % (2 + W);
      #1;
      check_output("b2b_stall", c, 32'(bus.stall_req), 32'(p <= W));
      check_output("b2b_ce_n", c, 32'(sram_ce_n), 32'(!(p >= 1 && p <= W)));
      if (p == W + 1) begin
        exp = exp_q.pop_front();
        check_output("b2b_rdata", c, bus.rdata_o, exp);
      end
      @(posedge clk);
      if (c == W + 2) begin
        #1;
        bus.ce_i = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    check_output("b2b_no_third", 0, 32'({sram_ce_n, bus.stall_req}), 32'b10);

    // Reset asserted in the second ACCESS cycle of a store.
    @(negedge clk);
    bus.ce_i    = 1'b1;
    bus.we_n_i  = 1'b0;
    bus.sel_i   = 4'b0000;
    bus.addr_i  = 32'h0000_0030;
    bus.wdata_i = 32'h55AA_55AA;
    @(posedge clk);
    #1;
    bus.ce_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_pre_we_n", 0, 32'({sram_ce_n, sram_we_n}), 32'b00);
    rst = 1'b0;
    #1;
    check_output("rst_mid_strobes", 0, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
    check_output("rst_mid_stall", 0, 32'(bus.stall_req), 32'h0);
    check_output("rst_mid_rdata", 0, bus.rdata_o, 32'h0);
    check_output("rst_mid_addr", 0, 32'(sram_addr), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("rst_after_idle", 0, 32'({sram_ce_n, bus.stall_req}), 32'b10);
    @(negedge clk);
    apply_stimulus(vecs[12], 100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
